buck_pwm_scheduler: RTL and testbench
=====================================

Name: buck_pwm_scheduler

Overview:
- Sequences the two-channel interleaved discharge buck stage at fs = 250 kHz (PERIOD = 400 clk).
- Generates the 4 us period timers consumed by the one-cycle duty controller.
- Captures the controller's inductor_charging_time once per channel per period and drives two gates 180° apart.
- Owns enable/stop/fault sequencing so the power stage only switches on period boundaries.

Parameters:
PERIOD, 400, clk cycles per switching period (4 us).
PHASE, 200, channel-1 offset in clk cycles (180°).
LATCH_CYC, 8, timer count at which a channel's on-time is captured (covers controller's 6-cycle pipeline + margin).
MAX_ON, 200, on-time clamp in clk cycles.
MIN_ON, 4, on-times below this are forced to 0.
SS_STEP, 8, soft-start clamp increment per period (only with SOFT_START_EN).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  level: request switching
fault  in  1  level: hardware fault (overcurrent/short)
fault_clr  in  1  single-cycle pulse: clear latched fault
inductor_charging_time  in  16  requested on-time, clk cycles, from duty controller
timer_buck_4us_0  out  16  channel-0 period timer 0..PERIOD-1
timer_buck_4us_1  out  16  channel-1 timer = (timer0+PHASE) mod PERIOD
gate_ch0  out  1  channel-0 switch drive
gate_ch1  out  1  channel-1 switch drive
running  out  1  high in RUN
fault_latched  out  1  high in FAULT
state  out  2  IDLE=0, ARM=1, RUN=2, FAULT=3 (DRAIN reported as 2)

Behaviour:
- Reset:
  - All outputs 0.
  - timer0 = 0, timer1 = PHASE.
  - Captured on-times 0.
  - State IDLE.
- Timers:
  - Free-running in every state so the controller keeps sampling.
  - timer0 wraps PERIOD-1 -> 0.
  - timer1 derived from timer0, no extra latency.
- Capture, ch0: when timer0 == LATCH_CYC, latch ton0 = clamp(inductor_charging_time). Same for ch1 on timer1 == LATCH_CYC.
- Clamp rule, unsigned:
  - v < MIN_ON -> 0.
  - v > MAX_ON -> MAX_ON.
  - Otherwise v.
- Gates:
  - gate_chN registered; high for timerN in [LATCH_CYC+1, LATCH_CYC+tonN].
  - Exactly tonN cycles high; tonN = 0 means no pulse.
  - Capture permitted only in RUN; outside RUN, tonN is forced to 0 at the capture point.
- FSM:
  - IDLE: enable=1 -> ARM.
  - ARM: enable=0 -> IDLE. At timer0 == PERIOD-1 -> RUN, so the first capture is in a full period.
  - RUN: enable=0 -> DRAIN.
  - DRAIN: no new captures. Pulses already in progress finish. Gates remain low for not-yet-captured channels. At timer0 == PERIOD-1 -> IDLE. enable re-asserted in DRAIN is ignored until IDLE.
- Fault:
  - fault=1 in any state -> FAULT on the next edge, and both gates forced low on that same edge.
  - Both tonN cleared.
  - fault has priority over enable and fault_clr.
  - FAULT -> IDLE only on fault_clr=1 with fault=0. enable must then be re-asserted, passing through ARM again.
- Simultaneous enable rise and fault: fault wins.
- Reset mid-pulse: gates drop immediately (async).

Optional Feature:
- Macro: BUCK_PWM_SOFT_START_EN.
- When defined:
  - Effective clamp ss_max starts at 0 on ARM->RUN.
  - ss_max increases by SS_STEP at each timer0 wrap in RUN, saturating at MAX_ON.
  - ss_max resets to 0 in IDLE and FAULT.
- When undefined: clamp is fixed MAX_ON; no ss_max register.

Test Plan:
- Timers: release rst, enable=0 -> timer0 counts 0..399 and wraps; timer1 reads 200 when timer0=0; gates stay 0.
- Nominal switching: enable=1, inductor_charging_time=120 -> first RUN period gate_ch0 high timer0 9..128 (120 cycles); gate_ch1 high timer1 9..128, i.e. timer0 209..328.
- Clamp: inputs 3 / 500 / 200 -> pulse widths 0 / 200 / 200 cycles.
- Drain: deassert enable at timer0=50 while gate_ch0 high with ton=120 -> ch0 pulse completes at timer0=128; ch1 gives no pulse; state IDLE after timer0=399.
- Fault: assert fault at timer0=60 mid-pulse -> gate_ch0 low next cycle, fault_latched=1, state=3. fault_clr while fault=1 -> no change. fault=0 then fault_clr -> IDLE; no switching until enable is re-asserted and ARM completes.
- Soft start (macro on): input 200 -> successive ch0 widths 8, 16, 24 ... reaching 200 at period 25 and holding.

Source files
------------

// File: rtl/buck_pwm_scheduler_if.sv
// Bundles the buck scheduler's control inputs and its timer/gate/status outputs.
// Latency: none (wires only).
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface buck_pwm_scheduler_if;
    logic        enable;
    logic        fault;
    logic        fault_clr;
    logic [15:0] inductor_charging_time;
    logic [15:0] timer_buck_4us_0;
    logic [15:0] timer_buck_4us_1;
    logic        gate_ch0;
    logic        gate_ch1;
    logic        running;
    logic        fault_latched;
    logic [1:0]  state;

    // Controller / supervisor side
    modport master (
        output enable, fault, fault_clr, inductor_charging_time,
        input  timer_buck_4us_0, timer_buck_4us_1, gate_ch0, gate_ch1,
               running, fault_latched, state
    );

    // Scheduler side
    modport slave (
        input  enable, fault, fault_clr, inductor_charging_time,
        output timer_buck_4us_0, timer_buck_4us_1, gate_ch0, gate_ch1,
               running, fault_latched, state
    );
endinterface

// File: rtl/buck_pwm_scheduler.sv
// Two-channel interleaved buck PWM scheduler: period timers, on-time capture, 180-degree gates, enable/fault FSM.
// Latency: gates/status registered (1 clk); fault forces gates low on the next edge, rst drops them asynchronously.
// Backpressure: none, timers free-run; macro BUCK_PWM_SOFT_START_EN adds a per-period ramping on-time clamp.
module buck_pwm_scheduler #(
    parameter int PERIOD    = 400,
    parameter int PHASE     = 200,
    parameter int LATCH_CYC = 8,
    parameter int MAX_ON    = 200,
    parameter int MIN_ON    = 4
`ifdef BUCK_PWM_SOFT_START_EN
    ,
    parameter int SS_STEP   = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    buck_pwm_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [15:0] LAST_CNT  = 16'(PERIOD - 1);
    localparam logic [15:0] LATCH_CNT = 16'(LATCH_CYC);
    localparam logic [15:0] MAX_ON_V  = 16'(MAX_ON);
    localparam logic [15:0] MIN_ON_V  = 16'(MIN_ON);

    state_t      st_q, st_nxt;
    logic [15:0] timer0_q, timer0_nxt, timer1;
    logic [15:0] ton0_q, ton1_q, ton0_nxt, ton1_nxt;
    logic [15:0] ton_req, clamp_max;
    logic        gate0_q, gate1_q, running_q, fault_latched_q;
    logic [1:0]  state_q;
    logic        wrap;

    // Channel-1 timer is channel 0 shifted by PHASE, modulo PERIOD
    function automatic logic [15:0] shift_phase(input logic [15:0] t);
        logic [16:0] s;
        s = {1'b0, t} + 17'(PHASE);
        if (s >= 17'(PERIOD))
            s = s - 17'(PERIOD);
        return s[15:0];
    endfunction

    // Gate window is [LATCH_CYC+1, LATCH_CYC+ton]; ton=0 gives an empty window
    function automatic logic in_pulse(input logic [15:0] t, input logic [15:0] ton);
        return (t > LATCH_CNT) && ({1'b0, t} <= ({1'b0, LATCH_CNT} + {1'b0, ton}));
    endfunction

    assign wrap       = (timer0_q == LAST_CNT);
    assign timer0_nxt = wrap ? 16'd0 : timer0_q + 16'd1;
    assign timer1     = shift_phase(timer0_q);

`ifdef BUCK_PWM_SOFT_START_EN
    logic [15:0] ss_max_q;

    // Soft-start clamp: cleared outside switching, steps up on every wrap that lands in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ss_max_q <= 16'd0;
        else if (bus.fault || st_q == ST_IDLE || st_q == ST_FAULT)
            ss_max_q <= 16'd0;
        else if (wrap && st_nxt == ST_RUN)
            ss_max_q <= (({1'b0, ss_max_q} + 17'(SS_STEP)) >= {1'b0, MAX_ON_V})
                        ? MAX_ON_V : ss_max_q + 16'(SS_STEP);
    end

    assign clamp_max = ss_max_q;
`else
    assign clamp_max = MAX_ON_V;
`endif

    // Clamp requested on-time: runts dropped, long pulses limited
    always_comb begin
        ton_req = bus.inductor_charging_time;
        if (bus.inductor_charging_time < MIN_ON_V)
            ton_req = 16'd0;
        else if (bus.inductor_charging_time > clamp_max)
            ton_req = clamp_max;
    end

    // Next state: fault overrides everything, power stage only starts/stops on wraps
    always_comb begin
        st_nxt = st_q;
        if (bus.fault) begin
            st_nxt = ST_FAULT;
        end else begin
            case (st_q)
                ST_IDLE:  if (bus.enable) st_nxt = ST_ARM;
                ST_ARM:   if (!bus.enable) st_nxt = ST_IDLE;
                          else if (wrap) st_nxt = ST_RUN;
                ST_RUN:   if (!bus.enable) st_nxt = ST_DRAIN;
                ST_DRAIN: if (wrap) st_nxt = ST_IDLE;
                ST_FAULT: if (bus.fault_clr) st_nxt = ST_IDLE;
                default:  st_nxt = ST_IDLE;
            endcase
        end
    end

    // On-time capture at each channel's latch point; only RUN may load a non-zero value
    always_comb begin
        ton0_nxt = ton0_q;
        ton1_nxt = ton1_q;
        if (bus.fault) begin
            ton0_nxt = 16'd0;
            ton1_nxt = 16'd0;
        end else begin
            if (timer0_q == LATCH_CNT)
                ton0_nxt = (st_q == ST_RUN) ? ton_req : 16'd0;
            if (timer1 == LATCH_CNT)
                ton1_nxt = (st_q == ST_RUN) ? ton_req : 16'd0;
        end
    end

    // Period timer, free-running in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer0_q <= 16'd0;
        else
            timer0_q <= timer0_nxt;
    end

    // Captured on-times and registered gates, evaluated against next-cycle timers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ton0_q  <= 16'd0;
            ton1_q  <= 16'd0;
            gate0_q <= 1'b0;
            gate1_q <= 1'b0;
        end else begin
            ton0_q  <= ton0_nxt;
            ton1_q  <= ton1_nxt;
            gate0_q <= in_pulse(timer0_nxt, ton0_nxt);
            gate1_q <= in_pulse(shift_phase(timer0_nxt), ton1_nxt);
        end
    end

    // FSM state with registered status outputs (DRAIN reports as RUN code)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q            <= ST_IDLE;
            running_q       <= 1'b0;
            fault_latched_q <= 1'b0;
            state_q         <= 2'd0;
        end else begin
            st_q            <= st_nxt;
            running_q       <= (st_nxt == ST_RUN);
            fault_latched_q <= (st_nxt == ST_FAULT);
            case (st_nxt)
                ST_IDLE:          state_q <= 2'd0;
                ST_ARM:           state_q <= 2'd1;
                ST_RUN, ST_DRAIN: state_q <= 2'd2;
                default:          state_q <= 2'd3;
            endcase
        end
    end

    assign bus.timer_buck_4us_0 = timer0_q;
    assign bus.timer_buck_4us_1 = timer1;
    assign bus.gate_ch0         = gate0_q;
    assign bus.gate_ch1         = gate1_q;
    assign bus.running          = running_q;
    assign bus.fault_latched    = fault_latched_q;
    assign bus.state            = state_q;
endmodule

// File: tb/tb_buck_pwm_scheduler.sv
// Directed bench for buck_pwm_scheduler: timers, clamp table, drain, fault, reset, soft start.
// Latency: expectations are per-cycle positions relative to the timer0 wrap.
// Backpressure: none; inputs driven on the falling edge, outputs sampled there too.
module tb_buck_pwm_scheduler;
    localparam int PERIOD = 400;
    localparam int PHASE  = 200;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int ict;
        int w0;
        int w1;
    } vec_t;

    vec_t tbl [7];

    buck_pwm_scheduler_if bus ();

    buck_pwm_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance to the falling edge where timer0 equals v (bounded)
    task automatic wait_t0(input int v);
        int n;
        n = 0;
        while (int'(bus.timer_buck_4us_0) != v && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_timer0_%0d", v), int'(n < 1000), 1);
    endtask

    // Called at timer0==0: ch0 over timer0 0..399, ch1 over timer1 0..399
    task automatic measure(output int w0, output int f0, output int l0,
                           output int w1, output int f1, output int l1);
        w0 = 0; f0 = -1; l0 = -1;
        w1 = 0; f1 = -1; l1 = -1;
        for (int i = 0; i < 600; i++) begin
            if (i < 400 && bus.gate_ch0) begin
                if (f0 < 0) f0 = i;
                l0 = i;
                w0++;
            end
            if (i >= 200 && bus.gate_ch1) begin
                if (f1 < 0) f1 = i - 200;
                l1 = i - 200;
                w1++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_t0, w0, f0, l0, w1, f1, l1, cnt0, cnt1, last0, n;

        tbl[0] = '{120, 120, 120};
        tbl[1] = '{3,   0,   0};
        tbl[2] = '{500, 200, 200};
        tbl[3] = '{200, 200, 200};
        tbl[4] = '{4,   4,   4};
        tbl[5] = '{201, 200, 200};
        tbl[6] = '{0,   0,   0};

        rst = 1'b1;
        bus.enable = 1'b0;
        bus.fault = 1'b0;
        bus.fault_clr = 1'b0;
        bus.inductor_charging_time = 16'd0;
        repeat (3) @(negedge clk);

        chk("rst_timer0", int'(bus.timer_buck_4us_0), 0);
        chk("rst_timer1", int'(bus.timer_buck_4us_1), PHASE);
        chk("rst_gate0", int'(bus.gate_ch0), 0);
        chk("rst_gate1", int'(bus.gate_ch1), 0);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_fault_latched", int'(bus.fault_latched), 0);
        chk("rst_state", int'(bus.state), 0);

        // Free-running timers with switching disabled
        rst = 1'b0;
        exp_t0 = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            exp_t0 = (exp_t0 + 1) % PERIOD;
            chk("timer0", int'(bus.timer_buck_4us_0), exp_t0);
            chk("timer1", int'(bus.timer_buck_4us_1), (exp_t0 + PHASE) % PERIOD);
            chk("idle_gates", int'(bus.gate_ch0 | bus.gate_ch1), 0);
        end

`ifdef BUCK_PWM_SOFT_START_EN
        wait_t0(100);
        bus.enable = 1'b1;
        bus.inductor_charging_time = 16'd200;
        wait_t0(0);
        for (int p = 1; p <= 26; p++) begin
            w0 = 0;
            for (int i = 0; i < PERIOD; i++) begin
                w0 += int'(bus.gate_ch0);
                @(negedge clk);
            end
            chk($sformatf("ss_width_p%0d", p), w0, (8 * p > 200) ? 200 : 8 * p);
        end
`else
        // Arm mid-period; RUN starts at the next wrap
        wait_t0(100);
        bus.enable = 1'b1;
        bus.inductor_charging_time = 16'(tbl[0].ict);
        @(negedge clk);
        chk("arm_state", int'(bus.state), 1);
        chk("arm_running", int'(bus.running), 0);
        wait_t0(0);
        chk("run_state", int'(bus.state), 2);
        chk("run_running", int'(bus.running), 1);

        // Clamp / width table
        for (int v = 0; v < 7; v++) begin
            bus.inductor_charging_time = 16'(tbl[v].ict);
            wait_t0(0);
            measure(w0, f0, l0, w1, f1, l1);
            chk($sformatf("v%0d_width_ch0", v), w0, tbl[v].w0);
            chk($sformatf("v%0d_width_ch1", v), w1, tbl[v].w1);
            if (tbl[v].w0 > 0) begin
                chk($sformatf("v%0d_first_ch0", v), f0, 9);
                chk($sformatf("v%0d_last_ch0", v), l0, 8 + tbl[v].w0);
                chk($sformatf("v%0d_first_ch1", v), f1, 9);
                chk($sformatf("v%0d_last_ch1", v), l1, 8 + tbl[v].w1);
            end
        end

        // Drain: drop enable mid ch0 pulse
        bus.inductor_charging_time = 16'd120;
        wait_t0(0);
        wait_t0(50);
        chk("drain_gate0_before", int'(bus.gate_ch0), 1);
        bus.enable = 1'b0;
        cnt0 = 0; cnt1 = 0; last0 = -1;
        for (int k = 51; k < PERIOD; k++) begin
            @(negedge clk);
            if (k == 51) begin
                chk("drain_state", int'(bus.state), 2);
                chk("drain_running", int'(bus.running), 0);
            end
            if (k == 300) bus.enable = 1'b1;
            if (bus.gate_ch0) begin
                cnt0++;
                last0 = k;
            end
            if (bus.gate_ch1) cnt1++;
        end
        chk("drain_ch0_cycles", cnt0, 78);
        chk("drain_ch0_last", last0, 128);
        chk("drain_ch1_cycles", cnt1, 0);
        @(negedge clk);
        chk("drain_to_idle", int'(bus.state), 0);
        @(negedge clk);
        chk("idle_to_arm", int'(bus.state), 1);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("arm_abort", int'(bus.state), 0);

        // Fault mid-pulse, clear sequence, re-arm
        bus.enable = 1'b1;
        wait_t0(0);
        chk("fault_pre_run", int'(bus.state), 2);
        wait_t0(60);
        chk("fault_gate0_before", int'(bus.gate_ch0), 1);
        bus.fault = 1'b1;
        @(negedge clk);
        chk("fault_gate0", int'(bus.gate_ch0), 0);
        chk("fault_latched", int'(bus.fault_latched), 1);
        chk("fault_state", int'(bus.state), 3);
        chk("fault_running", int'(bus.running), 0);
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        chk("clr_blocked", int'(bus.state), 3);
        bus.fault = 1'b0;
        repeat (2) @(negedge clk);
        chk("fault_hold", int'(bus.state), 3);
        chk("fault_gates", int'(bus.gate_ch0 | bus.gate_ch1), 0);
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        chk("clr_idle", int'(bus.state), 0);
        chk("clr_latched", int'(bus.fault_latched), 0);
        @(negedge clk);
        chk("rearm_state", int'(bus.state), 1);
        cnt0 = 0; n = 0;
        while (int'(bus.timer_buck_4us_0) != 0 && n < PERIOD) begin
            cnt0 += int'(bus.gate_ch0 | bus.gate_ch1);
            @(negedge clk);
            n++;
        end
        chk("rearm_reached_wrap", int'(n < PERIOD), 1);
        chk("rearm_gates_quiet", cnt0, 0);
        chk("rearm_run", int'(bus.state), 2);
        measure(w0, f0, l0, w1, f1, l1);
        chk("rearm_width_ch0", w0, 120);
        chk("rearm_width_ch1", w1, 120);
        chk("rearm_first_ch0", f0, 9);

        // Asynchronous reset during a pulse
        wait_t0(20);
        chk("rstmid_gate0_before", int'(bus.gate_ch0), 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_gate0", int'(bus.gate_ch0), 0);
        chk("rstmid_state", int'(bus.state), 0);
        chk("rstmid_timer0", int'(bus.timer_buck_4us_0), 0);
        @(negedge clk);
        bus.enable = 1'b0;
        rst = 1'b0;

        // Enable and fault together: fault wins
        @(negedge clk);
        chk("sim_pre_state", int'(bus.state), 0);
        bus.enable = 1'b1;
        bus.fault = 1'b1;
        @(negedge clk);
        chk("sim_state", int'(bus.state), 3);
        chk("sim_latched", int'(bus.fault_latched), 1);
        bus.enable = 1'b0;
        bus.fault = 1'b0;
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        chk("sim_cleared", int'(bus.state), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
